// File: rtl/criptografia_seq_pkg.sv
// Shared definitions for the keypad code encryptor: FSM state encodings,
// the per-digit word width and the largest supported code length.
package criptografia_seq_pkg;

    localparam int WORD_W     = 16;
    localparam int MAX_DIGITS = 8;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DONE    = 2'd1,
        ERROR   = 2'd2
    } state_t;

endpackage

// File: rtl/criptografia_digit.sv
// Combinational digit encoder: a BCD digit becomes a one-hot word, optionally
// rotated left by the slot index. Digits 10..15 raise the invalid flag.
module criptografia_digit
    import criptografia_seq_pkg::*;
#(
    parameter int ROTATE = 1
) (
    input  logic [3:0]        digit,
    input  logic [3:0]        shift,
    output logic [WORD_W-1:0] word,
    output logic              invalid
);

    logic [WORD_W-1:0]   onehot;
    logic [2*WORD_W-1:0] doubled;

    // Shifting a doubled copy and keeping the upper half gives a rotate-left.
    always_comb begin
        onehot  = 16'h0001 << digit;
        doubled = {onehot, onehot} << shift;
        if (ROTATE != 0) begin
            word = doubled[2*WORD_W-1:WORD_W];
        end else begin
            word = onehot;
        end
        invalid = (digit > 4'd9);
    end

endmodule

// File: rtl/criptografia_seq.sv
// Keypad code collector: accepts up to N_DIGITS BCD digits, encrypts each one
// into its own 16-bit slot and reports completion or an invalid entry.
module criptografia_seq
    import criptografia_seq_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int ROTATE   = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       digit_valid,
    input  logic [3:0]                 digit,
    input  logic                       ack,
    output logic                       ready,
    output logic [WORD_W*N_DIGITS-1:0] code,
    output logic [3:0]                 count,
    output logic                       done,
    output logic                       error
);

    state_t            state, state_nx;
    logic [WORD_W-1:0] word;
    logic              invalid;
    logic              accept;
    logic              store;
    logic              clear;

    criptografia_digit #(
        .ROTATE(ROTATE)
    ) u_digit (
        .digit  (digit),
        .shift  (count),
        .word   (word),
        .invalid(invalid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_nx;
        end
    end

    // ack outranks digit_valid in every state, so an aborted cycle never stores.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        store    = 1'b0;
        clear    = 1'b0;
        case (state)
            COLLECT: begin
                if (ack) begin
                    clear = 1'b1;
                end else if (digit_valid) begin
                    accept = 1'b1;
                    if (invalid) begin
                        state_nx = ERROR;
                    end else begin
                        store = 1'b1;
                        if (count == 4'(N_DIGITS - 1)) begin
                            state_nx = DONE;
                        end
                    end
                end
            end
            DONE, ERROR: begin
                if (ack) begin
                    clear    = 1'b1;
                    state_nx = COLLECT;
                end
            end
            default: state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            code  <= '0;
            count <= '0;
        end else if (store) begin
            for (int s = 0; s < N_DIGITS; s++) begin
                if (count == 4'(s)) begin
                    code[WORD_W*s +: WORD_W] <= word;
                end
            end
            count <= count + 4'd1;
        end
    end

    assign ready = (state == COLLECT);
    assign done  = (state == DONE);
    assign error = (state == ERROR);

endmodule

// File: tb/tb_criptografia_seq.sv
// Scoreboard bench: three configurations of criptografia_seq driven with
// directed digit sequences; expected outputs are queued and checked by a monitor.
module tb_criptografia_seq;
    import criptografia_seq_pkg::*;

    typedef struct {
        int           which;
        logic [127:0] code;
        logic [3:0]   count;
        logic         ready;
        logic         done;
        logic         error;
        string        name;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       dv    [3];
    logic [3:0] dg    [3];
    logic       ak    [3];

    logic        rdy   [3];
    logic        dn    [3];
    logic        er    [3];
    logic [3:0]  cnt   [3];
    logic [63:0]  code0;
    logic [63:0]  code1;
    logic [127:0] code2;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    // DUT 0: N=4 rotated, DUT 1: N=4 plain, DUT 2: N=8 rotated
    criptografia_seq #(.N_DIGITS(4), .ROTATE(1)) u_d0 (
        .clock(clock), .reset(reset), .digit_valid(dv[0]), .digit(dg[0]), .ack(ak[0]),
        .ready(rdy[0]), .code(code0), .count(cnt[0]), .done(dn[0]), .error(er[0]));
    criptografia_seq #(.N_DIGITS(4), .ROTATE(0)) u_d1 (
        .clock(clock), .reset(reset), .digit_valid(dv[1]), .digit(dg[1]), .ack(ak[1]),
        .ready(rdy[1]), .code(code1), .count(cnt[1]), .done(dn[1]), .error(er[1]));
    criptografia_seq #(.N_DIGITS(8), .ROTATE(1)) u_d2 (
        .clock(clock), .reset(reset), .digit_valid(dv[2]), .digit(dg[2]), .ack(ak[2]),
        .ready(rdy[2]), .code(code2), .count(cnt[2]), .done(dn[2]), .error(er[2]));

    task automatic expect_out(input int w, input logic [127:0] c, input logic [3:0] n,
                              input logic r, input logic d, input logic e, input string nm);
        exp_t x;
        x.which = w; x.code = c; x.count = n;
        x.ready = r; x.done = d; x.error = e; x.name = nm;
        q.push_back(x);
    endtask

    // Apply one cycle of inputs to DUT w, then let the edge happen.
    task automatic cycle(input int w, input logic v, input logic [3:0] d, input logic a);
        dv[w] = v; dg[w] = d; ak[w] = a;
        @(posedge clock);
        #1;
        dv[w] = 1'b0; dg[w] = 4'd0; ak[w] = 1'b0;
    endtask

    // Monitor: outputs are stable at the falling edge.
    always @(negedge clock) begin
        while (q.size() > 0) begin
            exp_t x;
            logic [127:0] ac;
            logic [3:0]   an;
            logic         ar, ad, ae;
            x  = q.pop_front();
            ac = (x.which == 0) ? {64'd0, code0} : (x.which == 1) ? {64'd0, code1} : code2;
            an = cnt[x.which];
            ar = rdy[x.which];
            ad = dn[x.which];
            ae = er[x.which];
            total++;
            if (ac !== x.code || an !== x.count || ar !== x.ready ||
                ad !== x.done || ae !== x.error) begin
                bad++;
                $display("FAIL %s: got code=%h count=%0d ready=%b done=%b error=%b, want code=%h count=%0d ready=%b done=%b error=%b",
                         x.name, ac, an, ar, ad, ae, x.code, x.count, x.ready, x.done, x.error);
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            dv[i] = 1'b0; dg[i] = 4'd0; ak[i] = 1'b0;
        end
        // Reset with ack and digit_valid also high: reset wins.
        reset = 1'b1;
        dv[0] = 1'b1; dg[0] = 4'd3; ak[0] = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        dv[0] = 1'b0; dg[0] = 4'd0; ak[0] = 1'b0;
        for (int i = 0; i < 3; i++) expect_out(i, '0, 4'd0, 1, 0, 0, "reset_state");
        @(negedge clock);

        // Rotated N=4: 1,2,3,4
        cycle(0, 1, 4'd1, 0); expect_out(0, 128'h0002, 4'd1, 1, 0, 0, "rot_d1");
        cycle(0, 0, 4'd7, 0); expect_out(0, 128'h0002, 4'd1, 1, 0, 0, "rot_idle");
        cycle(0, 1, 4'd2, 0); expect_out(0, 128'h0008_0002, 4'd2, 1, 0, 0, "rot_d2");
        cycle(0, 1, 4'd3, 0); expect_out(0, 128'h0020_0008_0002, 4'd3, 1, 0, 0, "rot_d3");
        cycle(0, 1, 4'd4, 0); expect_out(0, 128'h0080_0020_0008_0002, 4'd4, 0, 1, 0, "rot_full");
        cycle(0, 1, 4'd9, 0); expect_out(0, 128'h0080_0020_0008_0002, 4'd4, 0, 1, 0, "done_ignore_dv");
        cycle(0, 0, 4'd0, 0); expect_out(0, 128'h0080_0020_0008_0002, 4'd4, 0, 1, 0, "done_hold");
        cycle(0, 0, 4'd0, 1); expect_out(0, '0, 4'd0, 1, 0, 0, "done_ack");

        // Invalid digit after a valid one
        cycle(0, 1, 4'd5, 0);  expect_out(0, 128'h0020, 4'd1, 1, 0, 0, "err_d5");
        cycle(0, 1, 4'd12, 0); expect_out(0, 128'h0020, 4'd1, 0, 0, 1, "err_d12");
        cycle(0, 1, 4'd3, 0);  expect_out(0, 128'h0020, 4'd1, 0, 0, 1, "err_hold");
        cycle(0, 0, 4'd0, 1);  expect_out(0, '0, 4'd0, 1, 0, 0, "err_ack");

        // Abort mid-entry with a simultaneous digit
        cycle(0, 1, 4'd1, 0); expect_out(0, 128'h0002, 4'd1, 1, 0, 0, "abort_d1");
        cycle(0, 1, 4'd2, 0); expect_out(0, 128'h0008_0002, 4'd2, 1, 0, 0, "abort_d2");
        cycle(0, 1, 4'd3, 1); expect_out(0, '0, 4'd0, 1, 0, 0, "abort_ack_wins");
        cycle(0, 1, 4'd0, 0); expect_out(0, 128'h0001, 4'd1, 1, 0, 0, "abort_restart");
        cycle(0, 0, 4'd0, 1); expect_out(0, '0, 4'd0, 1, 0, 0, "abort_clear");

        // Reset after three digits
        cycle(0, 1, 4'd1, 0); expect_out(0, 128'h0002, 4'd1, 1, 0, 0, "rst_d1");
        cycle(0, 1, 4'd2, 0); expect_out(0, 128'h0008_0002, 4'd2, 1, 0, 0, "rst_d2");
        cycle(0, 1, 4'd3, 0); expect_out(0, 128'h0020_0008_0002, 4'd3, 1, 0, 0, "rst_d3");
        reset = 1'b1;
        cycle(0, 1, 4'd4, 0);
        reset = 1'b0;
        expect_out(0, '0, 4'd0, 1, 0, 0, "rst_mid_entry");

        // Plain one-hot N=4: 1,2,3,4
        cycle(1, 1, 4'd1, 0); expect_out(1, 128'h0002, 4'd1, 1, 0, 0, "plain_d1");
        cycle(1, 1, 4'd2, 0); expect_out(1, 128'h0004_0002, 4'd2, 1, 0, 0, "plain_d2");
        cycle(1, 1, 4'd3, 0); expect_out(1, 128'h0008_0004_0002, 4'd3, 1, 0, 0, "plain_d3");
        cycle(1, 1, 4'd4, 0); expect_out(1, 128'h0010_0008_0004_0002, 4'd4, 0, 1, 0, "plain_full");
        reset = 1'b1;
        cycle(1, 0, 4'd0, 0);
        reset = 1'b0;
        expect_out(1, '0, 4'd0, 1, 0, 0, "rst_in_done");

        // N=8 rotated: seven zeros then 9, slot 7 wraps to bit 0
        for (int s = 0; s < 7; s++) cycle(2, 1, 4'd0, 0);
        expect_out(2, 128'h0040_0020_0010_0008_0004_0002_0001, 4'd7, 1, 0, 0, "n8_seven");
        cycle(2, 1, 4'd9, 0);
        expect_out(2, 128'h0001_0040_0020_0010_0008_0004_0002_0001, 4'd8, 0, 1, 0, "n8_wrap");
        cycle(2, 0, 4'd0, 1); expect_out(2, '0, 4'd0, 1, 0, 0, "n8_ack");

        @(negedge clock);
        @(negedge clock);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
